tdm_deinterleave_buffer: RTL and testbench

- Sits directly downstream of the round-robin TDM multiply stage. Consumes its single 16-bit product stream, which interleaves channels in round-robin order.
- Re-derives which channel each product belongs to, aligned to the multiplier pipeline latency.
- Writes each product into a per-channel FWFT FIFO.
- Each channel drains independently through its own valid/ready port.

---
 rtl/tdm_pkg.sv | 16 +
 rtl/tdm_deinterleave_buffer_chan_fifo.sv | 52 +++++
 rtl/tdm_deinterleave_buffer.sv | 89 ++++++++
 tb/tb_tdm_deinterleave_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM de-interleave buffer.
// The channel tag travels alongside the multiplier pipeline as a tag_t.
package tdm_pkg;

  localparam int TDM_NUM_CH     = 2;
  localparam int TDM_DATA_WIDTH = 16;
  localparam int TDM_PIPE_LAT   = 4;

  typedef logic [$clog2(TDM_NUM_CH)-1:0] chan_idx_t;

  typedef struct packed {
    logic      valid;
    chan_idx_t idx;
  } tag_t;

endpackage

// File: rtl/tdm_deinterleave_buffer_chan_fifo.sv
// First-word-fall-through FIFO for one TDM channel.
// When full, a push is accepted only if a pop happens in the same cycle.
module chan_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  not_empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign do_pop    = pop && not_empty;
  assign do_push   = push && (!full || do_pop);

  // Empty FIFO presents zero rather than a stale entry.
  assign head = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // On a full push+pop the write lands in the slot being vacated by the pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tdm_deinterleave_buffer.sv
// Splits the round-robin TDM product stream into per-channel FWFT FIFOs,
// tagging each product with the channel selected PIPE_LAT cycles earlier.
module tdm_deinterleave_buffer
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH = TDM_DATA_WIDTH,
  parameter int NUM_CH     = TDM_NUM_CH,   // must match TDM_NUM_CH (sizes chan_idx_t)
  parameter int DEPTH      = 4,
  parameter int PIPE_LAT   = TDM_PIPE_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sync_in,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout_data,
  output logic [NUM_CH-1:0]            dout_valid,
  input  logic [NUM_CH-1:0]            dout_ready,
  output logic [NUM_CH-1:0]            overflow,
  output logic                         sync_err
);

  // Each output channel is a valid/ready port: a word transfers on any
  // rising edge where valid && ready; data holds while valid && !ready.

  chan_idx_t   phase;
  chan_idx_t   phase_next;
  logic        locked;
  tag_t        cur_tag;
  tag_t        tag_pipe [PIPE_LAT];
  tag_t        aligned;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] full;

  assign phase_next    = (phase == chan_idx_t'(NUM_CH-1)) ? '0 : phase + 1'b1;
  assign cur_tag.valid = sync_in || locked;
  assign cur_tag.idx   = sync_in ? '0 : phase;
  assign aligned       = tag_pipe[PIPE_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      // A sync always re-aligns; a misplaced one is flagged once.
      sync_err <= sync_in && locked && (phase != '0);
      if (sync_in) begin
        phase  <= chan_idx_t'(1);
        locked <= 1'b1;
      end else begin
        phase  <= phase_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= cur_tag;
      for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = aligned.valid && (aligned.idx == chan_idx_t'(c));

    chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[c]),
      .push_data (din),
      .pop       (dout_ready[c]),
      .head      (dout_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .not_empty (dout_valid[c]),
      .full      (full[c])
    );

    // Full implies valid, so ready alone tells whether a slot frees up.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       overflow[c] <= 1'b0;
      else if (push[c] && full[c] && !dout_ready[c]) overflow[c] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdm_deinterleave_buffer.sv
// Randomized bench for tdm_deinterleave_buffer against a queue-based model
// that derives channel ownership from the time elapsed since the last sync.
module tb_tdm_deinterleave_buffer;

  localparam int DW    = 16;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sync_in = 1'b0;
  logic [DW-1:0]     din = '0;
  logic [NCH*DW-1:0] dout_data;
  logic [NCH-1:0]    dout_valid;
  logic [NCH-1:0]    dout_ready = '0;
  logic [NCH-1:0]    overflow;
  logic              sync_err;

  tdm_deinterleave_buffer #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .DEPTH      (DEPTH),
    .PIPE_LAT   (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .din        (din),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .sync_err   (sync_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0]  exp_q [NCH][$];
  int             tag_dly [$];
  logic [NCH-1:0] exp_ovf;
  logic           exp_sync_err;
  bit             m_locked;
  int             m_since;
  int             cycle;
  int             n_checks = 0;
  int             n_pass   = 0;
  int             stall_cnt;
  logic [DW-1:0]  stall_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
    tag_dly.delete();
    for (int i = 0; i < LAT; i++) tag_dly.push_back(-1);
    exp_ovf      = '0;
    exp_sync_err = 1'b0;
    m_locked     = 1'b0;
    m_since      = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic s, input logic [DW-1:0] d, input logic [NCH-1:0] r);
    int     cur;
    int     al;
    int     sz [NCH];
    logic [NCH-1:0] popped;
    exp_sync_err = s && m_locked && ((m_since % NCH) != 0);
    if (s)             cur = 0;
    else if (m_locked) cur = m_since % NCH;
    else               cur = -1;
    if (s) begin
      m_locked = 1'b1;
      m_since  = 1;
    end else begin
      m_since++;
    end
    al = tag_dly.pop_front();
    tag_dly.push_back(cur);
    for (int c = 0; c < NCH; c++) begin
      sz[c]     = exp_q[c].size();
      popped[c] = (sz[c] > 0) && r[c];
      if (popped[c]) void'(exp_q[c].pop_front());
    end
    if (al >= 0) begin
      if (sz[al] == DEPTH && !popped[al]) exp_ovf[al] = 1'b1;
      else exp_q[al].push_back(d);
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("valid%0d", c), 32'(dout_valid[c]), 32'(exp_q[c].size() > 0));
      if (exp_q[c].size() > 0)
        check($sformatf("data%0d", c), 32'(dout_data[c*DW +: DW]), 32'(exp_q[c][0]));
      check($sformatf("ovf%0d", c), 32'(overflow[c]), 32'(exp_ovf[c]));
    end
    check("sync_err", 32'(sync_err), 32'(exp_sync_err));
  endtask

  // driver: one cycle, checks the state left by the previous edge first
  task automatic step(input logic s, input logic [DW-1:0] d, input logic [NCH-1:0] r);
    @(negedge clk);
    check_outputs();
    sync_in    = s;
    din        = d;
    dout_ready = r;
    model_step(s, d, r);
    cycle++;
  endtask

  initial begin
    cycle = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(dout_valid), 32'(0));
    check("rst_data", dout_data, 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_sync_err", 32'(sync_err), 32'(0));
    rst = 1'b0;

    // unlocked: nothing may be pushed
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0100 + 16'(cycle), 2'b00);

    // sync, then fill both FIFOs well past DEPTH with no readers
    step(1'b1, 16'h0100 + 16'(cycle), 2'b00);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0100 + 16'(cycle), 2'b00);

    // ch0 drained while full: pushes keep landing, no new overflow
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0100 + 16'(cycle), 2'b01);

    // misplaced sync, then catch up on a free-running stream
    for (int i = 0; i < 4; i++) step(1'b0, 16'(cycle), 2'b11);
    while ((m_since % NCH) == 0) step(1'b0, 16'(cycle), 2'b11);
    step(1'b1, 16'h5A00 + 16'(cycle), 2'b11);
    for (int i = 0; i < 12; i++) step(1'b0, 16'h5A00 + 16'(cycle), 2'b11);

    // random traffic with occasional syncs
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 15) == 0), 16'($urandom), 2'($urandom_range(0, 3)));

    // stall ch1 for 10 cycles, then release for a single pop
    for (int i = 0; i < 12 && exp_q[1].size() < 2; i++) step(1'b0, 16'($urandom), 2'b00);
    stall_cnt = 0;
    stall_val = dout_data[DW +: DW];
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'($urandom), 2'b00);
      check("stall_hold1", 32'(dout_data[DW +: DW]), 32'(stall_val));
    end
    step(1'b0, 16'($urandom), 2'b10);
    for (int i = 0; i < 4; i++) step(1'b0, 16'($urandom), 2'b00);

    // async reset mid-operation discards everything, seen before any edge
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(dout_valid), 32'(0));
    check("arst_ovf", 32'(overflow), 32'(0));
    model_reset();
    sync_in    = 1'b0;
    dout_ready = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 16'($urandom), 2'b00);
    step(1'b1, 16'($urandom), 2'b00);
    for (int i = 0; i < 10; i++) step(1'b0, 16'($urandom), 2'($urandom_range(0, 3)));
    @(negedge clk);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
